// File: rtl/core2wb_pipe_if.sv
// Signal bundle between a core-style requester, the core2wb_pipe bridge and a Wishbone B4 pipelined slave.
// The bridge uses the master modport; the core/fabric side (or a bench) uses slave.
interface core2wb_pipe_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                   core_req;
    logic                   core_gnt;
    logic                   core_we;
    logic [AddrWidth-1:0]   core_addr;
    logic [DataWidth/8-1:0] core_be;
    logic [DataWidth-1:0]   core_wdata;
    logic                   core_rvalid;
    logic [DataWidth-1:0]   core_rdata;
    logic                   core_err;

    logic                   wb_cyc_o;
    logic                   wb_stb_o;
    logic                   wb_we_o;
    logic [AddrWidth-1:0]   wb_adr_o;
    logic [DataWidth/8-1:0] wb_sel_o;
    logic [DataWidth-1:0]   wb_dat_o;
    logic                   wb_stall_i;
    logic                   wb_ack_i;
    logic                   wb_err_i;
    logic [DataWidth-1:0]   wb_dat_i;

    modport master (
        input  core_req, core_we, core_addr, core_be, core_wdata,
        output core_gnt, core_rvalid, core_rdata, core_err,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
    );

    modport slave (
        output core_req, core_we, core_addr, core_be, core_wdata,
        input  core_gnt, core_rvalid, core_rdata, core_err,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
    );
endinterface

// File: rtl/core2wb_pipe.sv
// Core req/gnt/rvalid to Wishbone B4 pipelined bridge with up to MaxOutstanding transactions in flight.
// Define CORE2WB_PIPE_TIMEOUT_EN to add the bus-timeout abort (FLUSH state returning error responses).
module core2wb_pipe #(
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2,
    parameter int TimeoutCycles  = 255
) (
    input  logic clk,
    input  logic rst,
    core2wb_pipe_if.master bus
);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    if (MaxOutstanding < 1 || MaxOutstanding > 8) begin : g_bad_outstanding
        $error("core2wb_pipe: MaxOutstanding must be 1..8");
    end
    if (TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_bad_timeout
        $error("core2wb_pipe: TimeoutCycles must be 1..65535");
    end
    if (AddrWidth < 1 || DataWidth < 8 || (DataWidth % 8) != 0) begin : g_bad_width
        $error("core2wb_pipe: illegal AddrWidth/DataWidth");
    end

    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 rvalid_q, rvalid_d;
    logic                 err_q, err_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    logic run, full, busy, stb, gnt, rsp;

    assign full = (cnt_q == CntMax);
    assign busy = (cnt_q != '0);

`ifdef CORE2WB_PIPE_TIMEOUT_EN
    localparam logic [0:0]  RUN       = 1'b0;
    localparam logic [0:0]  FLUSH     = 1'b1;
    localparam logic [15:0] TimeLimit = 16'(TimeoutCycles);

    logic [0:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;

    assign run = (state_q == RUN);

    // Timer only runs while something is outstanding and the slave is silent.
    always_comb begin
        timer_d = '0;
        state_d = state_q;
        if (state_q == RUN) begin
            if (busy && !(bus.wb_ack_i || bus.wb_err_i)) begin
                timer_d = timer_q + 16'd1;
            end
            if (timer_d == TimeLimit) begin
                state_d = FLUSH;
            end
        end else if (cnt_q <= CntOne) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end
`else
    assign run = 1'b1;
`endif

    assign stb = run & bus.core_req & ~full;
    assign gnt = stb & ~bus.wb_stall_i;
    assign rsp = run & busy & (bus.wb_ack_i | bus.wb_err_i);

    // Outside RUN every cycle retires one aborted transaction with an error.
    always_comb begin
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        if (run) begin
            cnt_d = cnt_q + CntW'(gnt) - CntW'(rsp);
            if (rsp) begin
                rvalid_d = 1'b1;
                err_d    = bus.wb_err_i;
                rdata_d  = bus.wb_dat_i;
            end
        end else if (busy) begin
            cnt_d    = cnt_q - CntOne;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.core_gnt    = gnt;
    assign bus.core_rvalid = rvalid_q;
    assign bus.core_rdata  = rdata_q;
    assign bus.core_err    = err_q;

    assign bus.wb_cyc_o = run & (stb | busy);
    assign bus.wb_stb_o = stb;
    assign bus.wb_we_o  = bus.core_we;
    assign bus.wb_adr_o = bus.core_addr;
    assign bus.wb_sel_o = bus.core_be;
    assign bus.wb_dat_o = bus.core_wdata;
endmodule

// File: doc/core2wb_pipe.md
# core2wb_pipe

Parametrised bridge from the core-style request/grant/rvalid protocol to a Wishbone B4 pipelined master, allowing up to MaxOutstanding transactions in flight. It sits between a bus master and the system Wishbone fabric, replacing the single-outstanding core2wb adapter wherever sustained one-per-cycle throughput is needed. It also adds an optional bus-timeout abort that returns error responses for hung transactions.

## Interface
- AddrWidth, 32, address width
- DataWidth, 32, data width; multiple of 8
- MaxOutstanding, 2, maximum accepted-but-unanswered transactions; legal 1..8
- TimeoutCycles, 255, cycles without ack/err before abort; legal 1..65535
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- core_req  in  1  request valid
- core_gnt  out  1  request accepted this cycle
- core_we  in  1  write enable
- core_addr  in  AddrWidth  byte address
- core_be  in  DataWidth/8  byte enables
- core_wdata  in  DataWidth  write data
- core_rvalid  out  1  response valid; one per granted request
- core_rdata  out  DataWidth  read data, valid with core_rvalid
- core_err  out  1  response error, valid with core_rvalid
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o  out  1/AddrWidth/DataWidth/8/DataWidth  passthrough of core_we/addr/be/wdata
- wb_stall_i  in  1  slave stall
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error
- wb_dat_i  in  DataWidth  slave read data

## Operation
- Outstanding counter `cnt` (width clog2(MaxOutstanding+1)); `full` = cnt==MaxOutstanding.
- States: RUN, FLUSH.
- RUN: wb_stb_o = core_req & !full; core_gnt = wb_stb_o & !wb_stall_i; wb_cyc_o = wb_stb_o | (cnt!=0).
- cnt += core_gnt, cnt -= (wb_ack_i|wb_err_i) & cnt!=0; simultaneous grant and response leaves cnt unchanged.
- ack/err with cnt==0 is spurious: ignored, no response, cnt stays 0.
- ack and err in the same cycle: treated as err.
- Response register: on ack/err with cnt!=0, next cycle core_rvalid=1, core_rdata=wb_dat_i (captured; write acks capture too), core_err=wb_err_i.
- Timeout counter: cleared on any ack/err, on grant while cnt==0, and whenever cnt==0; otherwise increments while cnt!=0. Reaching TimeoutCycles -> FLUSH.
- FLUSH: wb_cyc_o=wb_stb_o=core_gnt=0. One core_rvalid with core_err=1 and core_rdata=0 per cycle, decrementing cnt each cycle. All wb_ack_i/wb_err_i are ignored. When cnt reaches 0, return to RUN on the next cycle.
- Responses always return in request order; slave is required to answer in order.

## Timing
- Reset: wb_cyc_o=wb_stb_o=core_gnt=0, core_rvalid=0, core_err=0, core_rdata=0, cnt=0, timer=0, state RUN; wb_adr_o/sel/dat/we follow core inputs.
- Reset mid-transaction drops all in-flight transactions; no responses are issued for them.
- core_gnt is combinational in the same cycle as stb & !stall.
- Response latency: core_rvalid exactly 1 cycle after wb_ack_i/wb_err_i.
- Throughput: 1 transaction/cycle with MaxOutstanding>=2 and a zero-wait slave. MaxOutstanding=1 yields 1 per 2 cycles for a 1-cycle slave.
- Abort: first error response appears 1 cycle after the timer hits TimeoutCycles. The last response appears cnt cycles later.

## Configuration
- CORE2WB_PIPE_TIMEOUT_EN defined: timeout counter and FLUSH state present as above.
- Not defined: no timer, no FLUSH state; TimeoutCycles is ignored, and a hung slave stalls the bridge indefinitely.

## Test plan
- Single read, slave acks 1 cycle after stb with wb_dat_i=32'hDEADBEEF -> core_gnt in cycle 0, core_rvalid in cycle 2 with core_rdata=32'hDEADBEEF, core_err=0.
- 8 back-to-back writes, MaxOutstanding=2, zero-wait ack -> 8 grants in 8 consecutive cycles, 8 rvalids in order, cnt never exceeds 2.
- MaxOutstanding=2, slave holds ack off for 5 cycles -> third request sees core_gnt=0 and wb_stb_o=0 until the first ack, then is granted.
- wb_stall_i=1 for 3 cycles with core_req=1 -> wb_stb_o=1 and core_gnt=0 for 3 cycles, grant on cycle 4, address held.
- Timeout enabled, TimeoutCycles=16, 2 outstanding, no ack -> wb_cyc_o drops after 16 cycles, then 2 consecutive rvalids with core_err=1 and core_rdata=0. A late ack afterwards is ignored.
- Spurious wb_ack_i with cnt=0, then rst asserted with 1 outstanding -> no rvalid for either event, all outputs at reset values.
